// File: rtl/riscv_pkg.sv
// Shared constants and types for the fetch front end.
//   XLEN      : architectural width.
//   NOP_INSTR : ADDI x0,x0,0, presented on the outputs when nothing is queued.
//   PC_INC    : byte stride between sequential instruction fetches.
//   fetch_entry_t : one fetch-queue slot, {pc, instr}, 64 bits wide.
package riscv_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, the redirect
// source and decode.
//   master : fetch_unit side (drives imem_addr and the out_* / err signals)
//   slave  : environment side (memory, branch unit, decode)
interface fetch_unit_if;
  logic [riscv_pkg::XLEN-1:0] imem_addr;
  logic [riscv_pkg::XLEN-1:0] imem_instr;
  logic                       redirect_valid;
  logic [riscv_pkg::XLEN-1:0] redirect_pc;
  logic                       out_valid;
  logic                       out_ready;
  logic [riscv_pkg::XLEN-1:0] out_instr;
  logic [riscv_pkg::XLEN-1:0] out_pc;
  logic                       misalign_err;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, misalign_err,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, misalign_err,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Circular fetch queue. DEPTH must be a power of two (2 or 4) so the
// pointers wrap naturally.
//   i_push/i_wdata : write at tail
//   i_pop          : advance head (caller guarantees non-empty)
//   i_flush        : discard everything; wins over push/pop
//   o_rdata        : head slot, straight from storage
//   o_count        : occupancy 0..DEPTH
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count
);
  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [PW-1:0]               r_head, r_tail;
  logic [CW-1:0]               r_count;

  // Payload needs no reset: a slot is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_tail] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PW'(1);
      if (i_pop)  r_head <= r_head + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_head];
  assign o_count = r_count;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, fetch queue and redirect handling.
//   clk, rst_n : clock, async active-low reset
//   io_bus     : imem_addr/imem_instr to memory, redirect_valid/redirect_pc
//                from the branch unit, out_* handshake to decode,
//                misalign_err pulse for a redirect target not word-aligned.
// Outputs come only from registered state, so imem_instr never reaches
// out_* within a cycle.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  io_bus
);
  localparam int            CW   = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

  logic [XLEN-1:0] r_pc;
  logic            r_misalign;
  logic [CW-1:0]   w_count;
  logic            w_valid, w_deq, w_enq;
  fetch_entry_t    w_head, w_new;

  assign w_valid = (w_count != '0);
  assign w_deq   = w_valid & io_bus.out_ready;
  // A full queue can still take a fetch when decode drains the head this cycle.
  assign w_enq   = ~io_bus.redirect_valid & ((w_count != FULL) | w_deq);

  assign w_new.pc    = r_pc;
  assign w_new.instr = io_bus.imem_instr;

  fetch_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(2 * XLEN)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_enq),
    .i_pop   (w_deq),
    .i_flush (io_bus.redirect_valid),
    .i_wdata (w_new),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  // Redirect dominates; the low two target bits are dropped, not trapped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_pc <= RESET_PC;
    else if (io_bus.redirect_valid) r_pc <= {io_bus.redirect_pc[XLEN-1:2], 2'b00};
    else if (w_enq)                 r_pc <= r_pc + PC_INC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_misalign <= 1'b0;
    else        r_misalign <= io_bus.redirect_valid & (|io_bus.redirect_pc[1:0]);
  end

  assign io_bus.imem_addr    = r_pc;
  assign io_bus.out_valid    = w_valid;
  assign io_bus.out_instr    = w_valid ? w_head.instr : NOP_INSTR;
  assign io_bus.out_pc       = w_valid ? w_head.pc    : '0;
  assign io_bus.misalign_err = r_misalign;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter QUEUE_DEPTH, default 2: fetch-queue entries; legal values are 2 and 4.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 imem_addr  output  32: byte address to instruction memory.
REQ-006 imem_instr  input  32: instruction word returned combinationally for imem_addr.
REQ-007 redirect_valid  input  1: branch/jump taken; load redirect_pc.
REQ-008 redirect_pc  input  32: redirect target byte address.
REQ-009 out_valid  output  1: head entry is valid for decode.
REQ-010 out_ready  input  1: decode accepts the head entry this cycle.
REQ-011 out_instr  output  32: head instruction.
REQ-012 out_pc  output  32: byte address of the head instruction.
REQ-013 misalign_err  output  1: one-cycle pulse for a redirect target with bits [1:0] != 0.

Function
REQ-014 imem_addr shall equal the PC register combinationally at all times.
REQ-015 Enqueue condition, evaluated per cycle with redirect_valid=0: count < QUEUE_DEPTH, or count == QUEUE_DEPTH and (out_valid & out_ready).
REQ-016 On each enqueue, the pair {PC, imem_instr} shall be written at the queue tail, and PC <= PC + 4 (mod 2^32).
REQ-017 A PC of 32'hFFFF_FFFC shall wrap to 32'h0000_0000 without error.
REQ-018 Dequeue shall occur when out_valid & out_ready; a simultaneous enqueue and dequeue shall leave count unchanged.
REQ-019 With no enqueue, PC shall hold its value.
REQ-020 out_valid shall equal (count != 0); out_instr and out_pc shall be taken from the head entry, registered storage only.
REQ-021 When the queue is empty, out_instr shall read 32'h0000_0013 (NOP) and out_pc shall read 0.
REQ-022 Latency: the first instruction appears at the outputs one cycle after its fetch edge; there is no combinational path from imem_instr to the out_* ports.
REQ-023 redirect_valid=1 shall take priority over all other events:
  - PC <= {redirect_pc[31:2], 2'b00}
  - the queue is flushed (count <= 0) on the same edge
  - no enqueue occurs that cycle
  - out_valid is 0 in the following cycle
REQ-024 A dequeue in the same cycle as a redirect shall still be considered consumed by decode; the flush discards only the remaining entries.
REQ-025 misalign_err shall be registered: high for exactly the one cycle after an edge on which redirect_valid=1 and redirect_pc[1:0] != 0, else low.
REQ-026 Back-to-back redirects shall each reload PC; only the last one determines the next fetch.

Reset
REQ-027 While rst_n=0, asynchronously:
  - PC = RESET_PC
  - count = 0, head and tail pointers = 0
  - out_valid = 0, out_instr = 32'h0000_0013, out_pc = 0
  - misalign_err = 0
REQ-028 Reset asserted mid-operation shall discard all queued entries; the first fetch after release shall occur on the first rising edge with rst_n=1.

Structure
REQ-029 Shared package riscv_pkg shall hold XLEN=32, NOP_INSTR=32'h0000_0013, and the PC increment constant 4.
REQ-030 The queue shall be a sub-module fetch_fifo, parameterised by depth and width 64, with push/pop/flush/count ports.
REQ-031 The PC register and the redirect/err logic shall live in fetch_unit.

Verification
REQ-032 Reset release with out_ready=1 and memory word[n] = n → out_pc sequence 0, 4, 8, 12 on consecutive cycles, out_instr = 0, 1, 2, 3, first out_valid one cycle after release.
REQ-033 out_ready=0 for 5 cycles → count saturates at QUEUE_DEPTH, PC holds at 8 (depth 2), out_pc stays 0; out_ready=1 then resumes in order with no loss or duplicate.
REQ-034 redirect_valid=1, redirect_pc=32'h40 while the queue is full → next cycle out_valid=0, imem_addr=32'h40; following cycle out_pc=32'h40.
REQ-035 redirect_pc=32'h42 → misalign_err high for exactly one cycle, then out_pc=32'h40.
REQ-036 RESET_PC=32'hFFFF_FFF8 → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 rst_n pulsed low for a cycle with 2 entries queued → out_valid=0 immediately, out_instr=NOP, fetch restarts at RESET_PC.
